// File: rtl/div_if.sv
// Handshake and operand bundle between the EX stage and the divider.
// The EX side drives the request and operands; the divider answers with
// a registered result and a ready flag.
interface div_if #(
    parameter int DATA_W = 32
);
    logic                  signed_div_i;
    logic [DATA_W-1:0]     opdata1_i;
    logic [DATA_W-1:0]     opdata2_i;
    logic                  start_i;
    logic                  annul_i;
    logic [2*DATA_W-1:0]   result_o;
    logic                  ready_o;

    modport master (
        output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        input  result_o, ready_o
    );

    modport slave (
        input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        output result_o, ready_o
    );
endinterface

// File: rtl/div.sv
// Multi-cycle restoring divider for the EX stage.
// Signed operands are reduced to magnitudes when a request is accepted,
// DATA_W shift-subtract steps run one per cycle, and the signs are fixed
// up on the final edge. The result is {remainder, quotient} and stays
// valid until the EX stage drops start_i.
module div #(
    parameter int DATA_W = 32
) (
    input  logic clk,
    input  logic rst,
    div_if.slave bus
);

    typedef enum logic [1:0] {
        FREE,
        BYZERO,
        ON,
        END
    } state_t;

    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] DONE_CNT = CNT_W'(DATA_W);

    state_t            state_q;
    state_t            state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [DATA_W-1:0] quo_q;
    logic [DATA_W-1:0] rem_q;
    logic [DATA_W-1:0] divisor_q;
    logic              neg_quo_q;
    logic              neg_rem_q;

    logic [DATA_W:0]   trial;
    logic              fits;
    logic [DATA_W-1:0] diff;
    logic [DATA_W-1:0] quo_fix;
    logic [DATA_W-1:0] rem_fix;
    logic              accept;
    logic              op1_neg;
    logic              op2_neg;

    // State register; reset returns the divider to idle at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= FREE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; annul beats start, and only FREE accepts a new request.
    always_comb begin
        state_d = state_q;
        case (state_q)
            FREE: begin
                if (bus.start_i && !bus.annul_i) begin
                    state_d = (bus.opdata2_i == '0) ? BYZERO : ON;
                end
            end
            BYZERO: begin
                state_d = bus.annul_i ? FREE : END;
            end
            ON: begin
                if (bus.annul_i) begin
                    state_d = FREE;
                end else if (cnt_q == DONE_CNT) begin
                    state_d = END;
                end
            end
            END: begin
                if (!bus.start_i) begin
                    state_d = FREE;
                end
            end
            default: state_d = FREE;
        endcase
    end

    // One restoring step: shift the next dividend bit into the partial
    // remainder and subtract the divisor if it fits; also the final sign fix.
    always_comb begin
        accept  = bus.start_i && !bus.annul_i;
        op1_neg = bus.signed_div_i && bus.opdata1_i[DATA_W-1];
        op2_neg = bus.signed_div_i && bus.opdata2_i[DATA_W-1];
        trial   = {rem_q, quo_q[DATA_W-1]};
        fits    = (trial >= {1'b0, divisor_q});
        diff    = trial[DATA_W-1:0] - divisor_q;
        quo_fix = neg_quo_q ? ({DATA_W{1'b0}} - quo_q) : quo_q;
        rem_fix = neg_rem_q ? ({DATA_W{1'b0}} - rem_q) : rem_q;
    end

    // Datapath and registered outputs, sequenced by the current state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q        <= '0;
            quo_q        <= '0;
            rem_q        <= '0;
            divisor_q    <= '0;
            neg_quo_q    <= 1'b0;
            neg_rem_q    <= 1'b0;
            bus.result_o <= '0;
            bus.ready_o  <= 1'b0;
        end else begin
            case (state_q)
                FREE: begin
                    bus.ready_o  <= 1'b0;
                    bus.result_o <= '0;
                    if (accept) begin
                        cnt_q     <= '0;
                        rem_q     <= '0;
                        quo_q     <= op1_neg ? ({DATA_W{1'b0}} - bus.opdata1_i) : bus.opdata1_i;
                        divisor_q <= op2_neg ? ({DATA_W{1'b0}} - bus.opdata2_i) : bus.opdata2_i;
                        neg_quo_q <= op1_neg ^ op2_neg;
                        neg_rem_q <= op1_neg;
                    end
                end
                BYZERO: begin
                    if (!bus.annul_i) begin
                        bus.ready_o  <= 1'b1;
                        bus.result_o <= '0;
                    end
                end
                ON: begin
                    if (bus.annul_i) begin
                        cnt_q <= '0;
                    end else if (cnt_q == DONE_CNT) begin
                        bus.result_o <= {rem_fix, quo_fix};
                        bus.ready_o  <= 1'b1;
                    end else begin
                        rem_q <= fits ? diff : trial[DATA_W-1:0];
                        quo_q <= {quo_q[DATA_W-2:0], fits};
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                END: begin
                    if (!bus.start_i) begin
                        bus.ready_o  <= 1'b0;
                        bus.result_o <= '0;
                    end
                end
                default: begin
                    bus.ready_o  <= 1'b0;
                    bus.result_o <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div.sv
// Directed bench for the divider: each request pushes its expected result
// and latency to a scoreboard, and the answer is popped when ready_o rises.
module tb_div;

    localparam int DATA_W = 32;

    typedef struct {
        string       tag;
        logic [63:0] res;
        int          edges;
    } exp_t;

    logic clk;
    logic rst;
    int   testsRun;
    int   testsFailed;
    exp_t sb[$];

    div_if #(.DATA_W(DATA_W)) bus ();

    div #(.DATA_W(DATA_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One comparison point: counts it and reports a mismatch with both values.
    task automatic checkEq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        testsRun++;
        assert (obs === exp) else begin
            testsFailed++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drives a request (called on a falling edge) and records what it should return.
    task automatic applyStimulus(input string tag, input logic sgn, input logic [31:0] a,
                                 input logic [31:0] b, input logic [63:0] res, input int edges);
        exp_t e;
        e.tag   = tag;
        e.res   = res;
        e.edges = edges;
        sb.push_back(e);
        bus.signed_div_i = sgn;
        bus.opdata1_i    = a;
        bus.opdata2_i    = b;
        bus.annul_i      = 1'b0;
        bus.start_i      = 1'b1;
    endtask

    // Waits for ready_o while scrambling the operands, then checks latency,
    // result, hold behaviour while start_i stays high, and the drop to idle.
    task automatic checkOutput();
        exp_t e;
        int   edges;
        logic seen;
        logic holdOk;
        edges = 0;
        seen  = 1'b0;
        while (edges < 100 && !seen) begin
            @(posedge clk);
            edges++;
            #1;
            if (bus.ready_o === 1'b1) seen = 1'b1;
            bus.opdata1_i    = $urandom;
            bus.opdata2_i    = $urandom;
            bus.signed_div_i = ~bus.signed_div_i;
        end
        if (sb.size() == 0) begin
            checkEq("scoreboard empty", 64'd1, 64'd0);
            return;
        end
        e = sb.pop_front();
        checkEq({e.tag, " ready seen"}, 64'(seen), 64'd1);
        checkEq({e.tag, " latency"}, 64'(edges), 64'(e.edges));
        checkEq({e.tag, " result"}, bus.result_o, e.res);
        holdOk = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (bus.ready_o !== 1'b1 || bus.result_o !== e.res) holdOk = 1'b0;
        end
        checkEq({e.tag, " hold"}, 64'(holdOk), 64'd1);
        @(negedge clk);
        bus.start_i = 1'b0;
        @(posedge clk);
        #1;
        checkEq({e.tag, " drop ready"}, 64'(bus.ready_o), 64'd0);
        checkEq({e.tag, " drop result"}, bus.result_o, 64'd0);
        @(negedge clk);
    endtask

    // Directed sequence covering the normal, zero, annul, reset and overflow cases.
    initial begin
        logic sawReady;
        testsRun         = 0;
        testsFailed      = 0;
        rst              = 1'b0;
        bus.start_i      = 1'b0;
        bus.annul_i      = 1'b0;
        bus.signed_div_i = 1'b0;
        bus.opdata1_i    = '0;
        bus.opdata2_i    = '0;

        #2;
        checkEq("reset ready", 64'(bus.ready_o), 64'd0);
        checkEq("reset result", bus.result_o, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        applyStimulus("u100/7", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 34);
        checkOutput();
        applyStimulus("s-7/2", 1'b1, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, 34);
        checkOutput();
        applyStimulus("s7/-2", 1'b1, 32'd7, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 34);
        checkOutput();
        applyStimulus("u5/0", 1'b0, 32'd5, 32'd0, 64'd0, 2);
        checkOutput();
        applyStimulus("s-5/0", 1'b1, 32'hFFFFFFFB, 32'd0, 64'd0, 2);
        checkOutput();
        applyStimulus("sovf", 1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 34);
        checkOutput();
        applyStimulus("uFFFFFFFF/3", 1'b0, 32'hFFFFFFFF, 32'd3, 64'h00000000_55555555, 34);
        checkOutput();

        // Annul part way through: no result, then a fresh request completes.
        bus.signed_div_i = 1'b0;
        bus.opdata1_i    = 32'hFFFFFFFF;
        bus.opdata2_i    = 32'd3;
        bus.start_i      = 1'b1;
        repeat (11) @(posedge clk);
        @(negedge clk);
        bus.annul_i = 1'b1;
        @(posedge clk);
        #1;
        checkEq("annul ready", 64'(bus.ready_o), 64'd0);
        @(negedge clk);
        bus.annul_i = 1'b0;
        bus.start_i = 1'b0;
        sawReady = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (bus.ready_o !== 1'b0) sawReady = 1'b1;
        end
        checkEq("annul no ready", 64'(sawReady), 64'd0);
        @(negedge clk);
        applyStimulus("u9/3", 1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 34);
        checkOutput();

        // Asynchronous reset mid-division, then accept on the first edge after release.
        bus.signed_div_i = 1'b0;
        bus.opdata1_i    = 32'd1000;
        bus.opdata2_i    = 32'd3;
        bus.start_i      = 1'b1;
        repeat (21) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        checkEq("rst ready", 64'(bus.ready_o), 64'd0);
        checkEq("rst result", bus.result_o, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        applyStimulus("uFFFFFFFF/16", 1'b0, 32'hFFFFFFFF, 32'h10, 64'h0000000F_0FFFFFFF, 34);
        checkOutput();

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/div.md
DIV -- requirements
Module: div

Interface
REQ-001 Parameter: DATA_W, default 32, operand width; result width is 2*DATA_W.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 signed_div_i  input  1  1 = signed (two's complement) division, 0 = unsigned.
REQ-005 opdata1_i  input  DATA_W  dividend.
REQ-006 opdata2_i  input  DATA_W  divisor.
REQ-007 start_i  input  1  division request from EX; EX holds it high until ready_o is seen.
REQ-008 annul_i  input  1  cancel the in-flight division (exception/flush).
REQ-009 result_o  output  2*DATA_W  {remainder, quotient}; upper half goes to HI, lower half to LO.
REQ-010 ready_o  output  1  result_o valid; EX drives stallreq_from_ex = start_i & ~ready_o.

Function
REQ-011 FSM states: FREE, BYZERO, ON, END; all outputs registered.
REQ-012 FREE: start_i=1 and annul_i=0 -> sample opdata1_i, opdata2_i and signed_div_i; divisor==0 -> BYZERO, else -> ON with step counter cnt=0.
REQ-013 FREE with start_i=0 or annul_i=1: stay FREE; ready_o=0, result_o=0.
REQ-014 Operands sampled only at acceptance; input changes after acceptance do not affect the result.
REQ-015 Signed mode: operate on magnitudes; negate quotient when operand signs differ; remainder takes the sign of the dividend.
REQ-016 ON: one restoring shift-subtract step per cycle, cnt increments by 1; after DATA_W steps (cnt==DATA_W) the next edge applies sign correction, loads result_o, sets ready_o=1 and enters END.
REQ-017 Latency: ready_o high after rising edge DATA_W+2 following the acceptance edge's preceding cycle (34 edges counting acceptance, DATA_W=32).
REQ-018 BYZERO: next edge -> END with result_o=0, ready_o=1 (ready after 2 edges counting acceptance).
REQ-019 END: hold result_o and ready_o while start_i=1; start_i=0 -> FREE, ready_o=0, result_o=0 on that edge.
REQ-020 annul_i=1 in ON or BYZERO -> FREE on the next edge; ready_o stays 0; no result produced.
REQ-021 start_i in ON/BYZERO/END is not a new request; a new division is accepted only from FREE.
REQ-022 Signed overflow 0x80000000 / 0xFFFFFFFF: quotient 0x80000000, remainder 0 (wraps, no trap).
REQ-023 Unsigned mode treats all operand bits as magnitude, no sign correction.
REQ-024 annul_i takes priority over start_i in the same cycle.

Reset
REQ-025 rst low: immediately, without a clock edge, state=FREE, cnt=0, ready_o=0, result_o=0, internal dividend/divisor registers cleared.
REQ-026 rst low mid-division aborts it; after rst rises, the block accepts a new start_i on the first edge.

Verification
REQ-027 Unsigned 100/7, start held -> ready_o rises after 34th edge, result_o=0x00000002_0000000E; held until start_i drops, then 0 next edge.
REQ-028 Signed 0xFFFFFFF9 (-7) / 2 -> result_o=0xFFFFFFFF_FFFFFFFD (rem -1, quo -3); signed 7/0xFFFFFFFE -> 0x00000001_FFFFFFFD.
REQ-029 Divisor 0, either mode -> ready_o high after 2nd edge, result_o=0; then start_i=0 -> FREE.
REQ-030 annul_i pulsed at step 10 of 0xFFFFFFFF/3 -> ready_o never rises; next start 9/3 completes with 0x00000000_00000003 in 34 edges.
REQ-031 rst pulsed low at step 20 -> ready_o=0, result_o=0 asynchronously; a following unsigned 0xFFFFFFFF/0x10 -> 0x0000000F_0FFFFFFF.
REQ-032 Signed 0x80000000/0xFFFFFFFF -> result_o=0x00000000_80000000; operands changed during ON do not alter it.
